// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan capture block.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StWaitDig,
      StWaitBlank
   } scan_state_e;

   localparam int unsigned DIG_IDX_W = 2;
   localparam logic [3:0]  AN_BLANK  = 4'b1111;

   // Active-high {a,b,c,d,e,f,g} glyphs, entry i is hex digit i.
   localparam logic [15:0][6:0] GLYPHS = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of an active-low segment pattern into a hex character.
module seg_glyph_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic [3:0] hex
);

   logic [6:0] lit;
   assign lit = ~seg;

   always_comb begin
      valid = 1'b0;
      hex   = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (lit == GLYPHS[i]) begin
            valid = 1'b1;
            hex   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Receives the multiplexed 4-digit 7-segment bus and rebuilds the displayed hex frame.
// Define SEG_SCAN_FRAME_CNT_EN to add the saturating frame_count output.
module seg_scan_capture
   import seg_scan_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset_sync,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] frame_chars,
   output logic        frame_valid,
   output logic        bad_seg,
   output logic        scan_err,
   output logic        timeout
`ifdef SEG_SCAN_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  STABLE_CNT = 8'(STABLE_CYCLES);

   logic [3:0] an_meta_q, an_sync_q, an_prev_q;
   logic [6:0] seg_meta_q, seg_sync_q, seg_prev_q;
   logic [7:0] stable_cnt_q, stable_cnt_d;
   logic       settled, multi_low, dig_hit, tmo_hit;
   logic [DIG_IDX_W-1:0] dig_j, dig_q, dig_d, sample_idx;
   scan_state_e state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic       sample, err_d, tmo_d, glyph_valid;
   logic [3:0] glyph_hex, sample_hex;
   logic [15:0] shadow_q, frame_chars_q;
   logic       frame_valid_q, bad_seg_q, scan_err_q, timeout_q;

   // Synchronisers reset to the blank bus so reset never looks like a digit.
   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         an_meta_q  <= AN_BLANK;
         an_sync_q  <= AN_BLANK;
         an_prev_q  <= AN_BLANK;
         seg_meta_q <= 7'h7F;
         seg_sync_q <= 7'h7F;
         seg_prev_q <= 7'h7F;
      end else begin
         an_meta_q  <= an;
         an_sync_q  <= an_meta_q;
         an_prev_q  <= an_sync_q;
         seg_meta_q <= seg;
         seg_sync_q <= seg_meta_q;
         seg_prev_q <= seg_sync_q;
      end
   end

   always_comb begin
      stable_cnt_d = stable_cnt_q;
      if ({an_sync_q, seg_sync_q} != {an_prev_q, seg_prev_q}) begin
         stable_cnt_d = 8'd0;
      end else if (stable_cnt_q != STABLE_CNT) begin
         stable_cnt_d = stable_cnt_q + 8'd1;
      end
   end

   assign settled   = (stable_cnt_q == STABLE_CNT);
   assign multi_low = ($countones(~an_sync_q) > 1);
   assign tmo_hit   = (state_q != StHunt) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      dig_hit = 1'b1;
      dig_j   = '0;
      case (an_sync_q)
         4'b1110: dig_j = 2'd0;
         4'b1101: dig_j = 2'd1;
         4'b1011: dig_j = 2'd2;
         4'b0111: dig_j = 2'd3;
         default: dig_hit = 1'b0;
      endcase
   end

   seg_glyph_decode u_decode (
      .seg   (seg_sync_q),
      .valid (glyph_valid),
      .hex   (glyph_hex)
   );

   assign sample_hex = glyph_valid ? glyph_hex : 4'h0;

   // Priority: anode fault, then timeout, then normal scan progress.
   always_comb begin
      state_d    = state_q;
      dig_d      = dig_q;
      sample     = 1'b0;
      sample_idx = dig_q;
      err_d      = 1'b0;
      tmo_d      = 1'b0;
      if (multi_low) begin
         err_d   = 1'b1;
         state_d = StHunt;
      end else begin
         unique case (state_q)
            StHunt: begin
               if (settled && an_sync_q == 4'b1110) begin
                  sample     = 1'b1;
                  sample_idx = '0;
                  dig_d      = '0;
                  state_d    = StWaitBlank;
               end
            end
            StWaitBlank: begin
               if (tmo_hit) begin
                  tmo_d   = 1'b1;
                  state_d = StHunt;
               end else if (an_sync_q == AN_BLANK) begin
                  dig_d   = dig_q + 2'd1;
                  state_d = StWaitDig;
               end
            end
            StWaitDig: begin
               if (settled && dig_hit && dig_j != dig_q) begin
                  err_d   = 1'b1;
                  state_d = StHunt;
               end else if (tmo_hit) begin
                  tmo_d   = 1'b1;
                  state_d = StHunt;
               end else if (settled && dig_hit) begin
                  sample  = 1'b1;
                  state_d = StWaitBlank;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   assign timer_d = (state_d != state_q || state_d == StHunt) ? '0 : timer_q + TMR_W'(1);

   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         state_q       <= StHunt;
         dig_q         <= '0;
         timer_q       <= '0;
         stable_cnt_q  <= 8'd0;
         shadow_q      <= 16'h0000;
         frame_chars_q <= 16'h0000;
         frame_valid_q <= 1'b0;
         bad_seg_q     <= 1'b0;
         scan_err_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         dig_q         <= dig_d;
         timer_q       <= timer_d;
         stable_cnt_q  <= stable_cnt_d;
         frame_valid_q <= sample && (sample_idx == 2'd3);
         bad_seg_q     <= sample && !glyph_valid;
         scan_err_q    <= err_d;
         timeout_q     <= tmo_d;
         if (sample) begin
            shadow_q[{sample_idx, 2'b00} +: 4] <= sample_hex;
            if (sample_idx == 2'd3) begin
               frame_chars_q <= {sample_hex, shadow_q[11:0]};
            end
         end
      end
   end

   assign frame_chars = frame_chars_q;
   assign frame_valid = frame_valid_q;
   assign bad_seg     = bad_seg_q;
   assign scan_err    = scan_err_q;
   assign timeout     = timeout_q;

`ifdef SEG_SCAN_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         frame_cnt_q <= 16'h0000;
      end else if (frame_valid_q && frame_cnt_q != 16'hFFFF) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: directed scans, monitor checks each frame_valid.
`timescale 1ns/1ps
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        reset_sync = 1'b1;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic [15:0] frame_chars;
   logic        frame_valid, bad_seg, scan_err, timeout;
`ifdef SEG_SCAN_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   int checks = 0;
   int errors = 0;
   int n_frame = 0, n_bad = 0, n_err = 0, n_tmo = 0;
   logic [15:0] exp_frames[$];

   seg_scan_capture dut (
      .clk         (clk),
      .reset_sync  (reset_sync),
      .an          (an),
      .seg         (seg),
      .frame_chars (frame_chars),
      .frame_valid (frame_valid),
      .bad_seg     (bad_seg),
      .scan_err    (scan_err),
      .timeout     (timeout)
`ifdef SEG_SCAN_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one comparison per frame_valid against the queued expectation.
   always @(posedge clk) begin
      #1;
      if (!reset_sync) begin
         if (frame_valid) begin
            n_frame++;
            if (exp_frames.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got frame_chars %h, expected no frame", frame_chars);
            end else begin
               check("frame_chars", {16'h0, frame_chars}, {16'h0, exp_frames.pop_front()});
            end
         end
         if (bad_seg)  n_bad++;
         if (scan_err) n_err++;
         if (timeout)  n_tmo++;
      end
   end

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] g;
      case (h)
         4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
         4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
         4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
      endcase
      return ~g;
   endfunction

   function automatic logic [3:0] an_of(input int k);
      case (k)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic blank(input int n);
      hold(4'hF, 7'h7F, n);
   endtask

   task automatic digit(input int k, input logic [6:0] s);
      hold(an_of(k), s, 20);
      blank(4);
   endtask

   task automatic scan_frame(input logic [15:0] c);
      for (int k = 0; k < 4; k++) digit(k, hex_seg(c[4*k +: 4]));
   endtask

   task automatic clear_counts();
      n_frame = 0; n_bad = 0; n_err = 0; n_tmo = 0;
   endtask

   task automatic expect_counts(input string tag, input int f, input int b, input int e,
                                input int t);
      check({tag, "_frames"},   n_frame, f);
      check({tag, "_bad_seg"},  n_bad, b);
      check({tag, "_scan_err"}, n_err, e);
      check({tag, "_timeout"},  n_tmo, t);
      check({tag, "_pending"},  exp_frames.size(), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_frame_chars", {16'h0, frame_chars}, 0);
      check("rst_pulses", {28'h0, frame_valid, bad_seg, scan_err, timeout}, 0);
      reset_sync = 1'b0;
      blank(10);

      // 1: clean "1234"
      clear_counts();
      exp_frames.push_back(16'h4321);
      scan_frame(16'h4321);
      expect_counts("clean", 1, 0, 0, 0);
      check("clean_held", {16'h0, frame_chars}, 32'h4321);

      // 2: 3-cycle glitch inside d1 must not be sampled
      clear_counts();
      exp_frames.push_back(16'h4321);
      digit(0, hex_seg(4'h1));
      hold(an_of(1), hex_seg(4'h2), 4);
      hold(an_of(1), 7'h00, 3);
      hold(an_of(1), hex_seg(4'h2), 20);
      blank(4);
      digit(2, hex_seg(4'h3));
      digit(3, hex_seg(4'h4));
      expect_counts("glitch", 1, 0, 0, 0);

      // 3: unknown pattern on d2 decodes as 0
      clear_counts();
      exp_frames.push_back(16'h4021);
      digit(0, hex_seg(4'h1));
      digit(1, hex_seg(4'h2));
      digit(2, 7'b1111110);
      digit(3, hex_seg(4'h4));
      expect_counts("badseg", 1, 1, 0, 0);

      // 4a: two anodes low for 20 cycles during d1
      clear_counts();
      digit(0, hex_seg(4'h1));
      hold(4'b1100, hex_seg(4'h2), 20);
      blank(4);
      digit(2, hex_seg(4'h3));
      digit(3, hex_seg(4'h4));
      expect_counts("multilow", 0, 0, 20, 0);
      check("multilow_held", {16'h0, frame_chars}, 32'h4021);

      // 4b: d2 where d1 expected
      clear_counts();
      digit(0, hex_seg(4'h1));
      digit(2, hex_seg(4'h3));
      digit(3, hex_seg(4'h4));
      expect_counts("order", 0, 0, 1, 0);

      clear_counts();
      exp_frames.push_back(16'h4321);
      scan_frame(16'h4321);
      expect_counts("recover", 1, 0, 0, 0);

      // 5: scan stops after d1
      clear_counts();
      digit(0, hex_seg(4'h1));
      hold(an_of(1), hex_seg(4'h2), 20);
      an  = 4'hF;
      seg = 7'h7F;
      n = 0;
      while (n_tmo == 0 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 4090 || n > 4110) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles, expected 4090..4110", n);
      end
      blank(20);
      expect_counts("timeout", 0, 0, 0, 1);
      clear_counts();
      exp_frames.push_back(16'h1234);
      scan_frame(16'h1234);
      expect_counts("post_timeout", 1, 0, 0, 0);

      // 6: reset mid-frame after d2 sampled
      clear_counts();
      digit(0, hex_seg(4'h5));
      digit(1, hex_seg(4'h6));
      digit(2, hex_seg(4'h7));
      reset_sync = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_frame_chars", {16'h0, frame_chars}, 0);
      check("midrst_frame_valid", {31'h0, frame_valid}, 0);
      reset_sync = 1'b0;
      blank(10);
      check("midrst_after", {16'h0, frame_chars}, 0);
      expect_counts("midrst", 0, 0, 0, 0);
`ifdef SEG_SCAN_FRAME_CNT_EN
      check("frame_count_rst", {16'h0, frame_count}, 0);
`endif
      clear_counts();
      exp_frames.push_back(16'hA5C0);
      exp_frames.push_back(16'h9E3B);
      exp_frames.push_back(16'hFD81);
      scan_frame(16'hA5C0);
      scan_frame(16'h9E3B);
      scan_frame(16'hFD81);
      blank(4);
      expect_counts("three", 3, 0, 0, 0);
`ifdef SEG_SCAN_FRAME_CNT_EN
      check("frame_count_3", {16'h0, frame_count}, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
